mig_port_tester: RTL

Self-checking memory test engine that drives one Spartan-6 MIG native user port (command, write-data and read-data FIFOs). On a start pulse it writes a configurable number of bursts of a generated pattern from a base address, then reads the same region back and compares every word. It reports an error count and the first failing address and data to host-visible wires. It is the in-fabric successor to the pipe-driven RAMTester write/read-back flow: parametrised in data width and burst length, with selectable patterns and no host data movement.

---
 rtl/mig_port_tester.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/mig_port_tester.sv
// mig_port_tester: write/read-back test engine for one Spartan-6 MIG user port.
// Define MIG_TESTER_PRBS_EN to build the LFSR pattern used by mode 2.
module mig_port_tester #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 30,
  parameter int BURST_LEN  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [31:0]             seed,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [15:0]             num_bursts,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [15:0]             err_count,
  output logic [ADDR_WIDTH-1:0]   first_err_addr,
  output logic [DATA_WIDTH-1:0]   first_err_data,
  output logic                    cmd_en,
  output logic [2:0]              cmd_instr,
  output logic [5:0]              cmd_bl,
  output logic [ADDR_WIDTH-1:0]   cmd_byte_addr,
  input  logic                    cmd_full,
  output logic                    wr_en,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic [DATA_WIDTH/8-1:0] wr_mask,
  input  logic                    wr_full,
  output logic                    rd_en,
  input  logic [DATA_WIDTH-1:0]   rd_data,
  input  logic                    rd_empty
);

  localparam int WB  = DATA_WIDTH / 8;
  localparam int REP = DATA_WIDTH / 32;
  localparam logic [ADDR_WIDTH-1:0] WORD_STEP  = ADDR_WIDTH'(WB);
  localparam logic [ADDR_WIDTH-1:0] BURST_STEP = ADDR_WIDTH'(BURST_LEN * WB);
  localparam logic [6:0] LAST_BEAT = 7'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    IDLE, WR_FILL, WR_CMD, RD_CMD, RD_DATA, DONE
  } state_t;

  state_t                state;
  logic [1:0]            mode_q;
  logic [31:0]           seed_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [15:0]           nb_q;
  logic [15:0]           burst;
  logic [6:0]            beat;
  logic [31:0]           idx;
  logic [31:0]           prbs;
  logic [31:0]           pat;
  logic [DATA_WIDTH-1:0] expected;
  logic                  accept_start;
  logic                  last_beat;
  logic                  last_burst;
  logic                  gen_load;
  logic                  gen_step;
  logic                  mismatch;
  logic [31:0]           load_seed;

  assign accept_start = (state == IDLE || state == DONE) && start;
  assign last_beat    = beat == LAST_BEAT;
  assign last_burst   = burst == nb_q - 16'd1;

  // Enables are gated by the FIFO flags so they can never fire into full/empty.
  assign cmd_en = !reset && !cmd_full &&
                  (state == WR_CMD || state == RD_CMD);
  assign wr_en  = !reset && !wr_full && state == WR_FILL;
  assign rd_en  = !reset && !rd_empty && state == RD_DATA;

  assign gen_load  = accept_start ||
                     (state == WR_CMD && cmd_en && last_burst);
  assign gen_step  = wr_en || rd_en;
  assign load_seed = accept_start ? seed : seed_q;

`ifdef MIG_TESTER_PRBS_EN
  logic [31:0] lfsr;
  assign prbs = lfsr;

  // Fibonacci LFSR, taps 32/22/2/1; an all-zero seed would lock up.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= '0;
    end else if (gen_load) begin
      lfsr <= (load_seed == 32'd0) ? 32'd1 : load_seed;
    end else if (gen_step) begin
      lfsr <= {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
    end
  end
`else
  assign prbs = idx;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
    end else if (gen_load) begin
      idx <= '0;
    end else if (gen_step) begin
      idx <= idx + 32'd1;
    end
  end

  always_comb begin
    pat = seed_q;
    unique case (mode_q)
      2'd0: pat = seed_q;
      2'd1: pat = idx;
      2'd2: pat = prbs;
      2'd3: pat = idx[0] ? ~seed_q : seed_q;
      default: pat = seed_q;
    endcase
  end

  assign expected = {REP{pat}};
  assign wr_data  = expected;
  assign wr_mask  = '0;
  assign mismatch = rd_en && (rd_data != expected);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      mode_q         <= '0;
      seed_q         <= '0;
      base_q         <= '0;
      nb_q           <= '0;
      burst          <= '0;
      beat           <= '0;
      word_addr      <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
      cmd_instr      <= '0;
      cmd_bl         <= '0;
      cmd_byte_addr  <= '0;
    end else begin
      cmd_bl <= 6'(BURST_LEN - 1);
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            mode_q         <= mode;
            seed_q         <= seed;
            base_q         <= base_addr;
            nb_q           <= num_bursts;
            burst          <= '0;
            beat           <= '0;
            cmd_byte_addr  <= base_addr;
            cmd_instr      <= 3'b000;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
            if (num_bursts == 16'd0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state <= WR_FILL;
              busy  <= 1'b1;
              done  <= 1'b0;
              pass  <= 1'b0;
            end
          end
        end
        WR_FILL: begin
          if (wr_en) begin
            if (last_beat) begin
              beat  <= '0;
              state <= WR_CMD;
            end else begin
              beat <= beat + 7'd1;
            end
          end
        end
        WR_CMD: begin
          if (cmd_en) begin
            if (last_burst) begin
              cmd_byte_addr <= base_q;
              word_addr     <= base_q;
              burst         <= '0;
              cmd_instr     <= 3'b001;
              state         <= RD_CMD;
            end else begin
              cmd_byte_addr <= cmd_byte_addr + BURST_STEP;
              burst         <= burst + 16'd1;
              state         <= WR_FILL;
            end
          end
        end
        RD_CMD: begin
          if (cmd_en) begin
            cmd_byte_addr <= cmd_byte_addr + BURST_STEP;
            state         <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rd_en) begin
            word_addr <= word_addr + WORD_STEP;
            if (mismatch) begin
              if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
              if (err_count == 16'd0) begin
                first_err_addr <= word_addr;
                first_err_data <= rd_data;
              end
            end
            if (last_beat) begin
              beat <= '0;
              if (last_burst) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                pass  <= (err_count == 16'd0) && !mismatch;
              end else begin
                burst <= burst + 16'd1;
                state <= RD_CMD;
              end
            end else begin
              beat <= beat + 7'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
